// File: rtl/dma_bus_arbiter_pkg.sv
// Shared types for the DMA bus arbiter: FSM state encoding, bus owner select
// and the default transfer length.
package dma_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HALT  = 3'd1,
        ST_ALIGN = 3'd2,
        ST_READ  = 3'd3,
        ST_WRITE = 3'd4,
        ST_DONE  = 3'd5
    } dma_state_e;

    typedef enum logic [1:0] {
        OWN_CPU    = 2'd0,
        OWN_DMA_RD = 2'd1,
        OWN_DMA_WR = 2'd2,
        OWN_NONE   = 2'd3
    } bus_owner_e;

    localparam int DMA_XFER_LEN_DEFAULT = 256;

endpackage

// File: rtl/dma_bus_arbiter_if.sv
// CPU, DMA-control and memory bus signals of the DMA bus arbiter.
// The arbiter side uses modport slave; the CPU/memory/test side uses master.
interface dma_bus_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
) ();
    // Handshake: dma_start is a one-cycle request, accepted only while
    // dma_busy=0 and dropped otherwise. cpu_rdy=0 stalls CPU read cycles;
    // CPU write cycles always complete. dma_done pulses once per finished copy.
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_we;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_rdy;
    logic              dma_start;
    logic [7:0]        dma_page;
    logic [ADDR_W-1:0] dma_dst;
    logic              dma_busy;
    logic              dma_done;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  cpu_addr, cpu_wdata, cpu_we, dma_start, dma_page, dma_dst, mem_rdata,
        output cpu_rdata, cpu_rdy, dma_busy, dma_done, mem_addr, mem_wdata, mem_we
    );

    modport master (
        output cpu_addr, cpu_wdata, cpu_we, dma_start, dma_page, dma_dst, mem_rdata,
        input  cpu_rdata, cpu_rdy, dma_busy, dma_done, mem_addr, mem_wdata, mem_we
    );
endinterface

// File: rtl/dma_bus_mux.sv
// Memory-side bus selection between the CPU and the DMA read/write phases.
module dma_bus_mux
    import dma_arb_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
) (
    input  bus_owner_e        owner_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_wdata_i,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [ADDR_W-1:0] hold_addr_i,
    input  logic [DATA_W-1:0] buf_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic              mem_we_o
);

    always_comb begin
        mem_addr_o  = cpu_addr_i;
        mem_wdata_o = cpu_wdata_i;
        mem_we_o    = cpu_we_i;
        case (owner_i)
            OWN_CPU: begin
                mem_addr_o  = cpu_addr_i;
                mem_wdata_o = cpu_wdata_i;
                mem_we_o    = cpu_we_i;
            end
            OWN_DMA_RD: begin
                mem_addr_o  = rd_addr_i;
                mem_wdata_o = buf_i;
                mem_we_o    = 1'b0;
            end
            OWN_DMA_WR: begin
                mem_addr_o  = wr_addr_i;
                mem_wdata_o = buf_i;
                mem_we_o    = 1'b1;
            end
            default: begin
                // Dead cycles keep the last DMA address parked on the bus.
                mem_addr_o  = hold_addr_i;
                mem_wdata_o = buf_i;
                mem_we_o    = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/dma_bus_arbiter.sv
// Page-copy DMA sharing the 6502 bus: halts the CPU via RDY, copies XFER_LEN
// bytes from a page to one register. Macro DMA_ALIGN_EN adds READ-parity alignment.
module dma_bus_arbiter
    import dma_arb_pkg::*;
#(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 8,
    parameter int XFER_LEN = DMA_XFER_LEN_DEFAULT
) (
    input  logic                     clk,
    input  logic                     reset,
    dma_bus_arbiter_if.slave         bus,
    output dma_state_e               dbg_state_o
);

    localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

    dma_state_e        state_q, state_d;
    logic [7:0]        page_q, page_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [7:0]        idx_q, idx_d;
    logic [DATA_W-1:0] buf_q, buf_d;
    logic              cpu_rdy_q;

    bus_owner_e        owner;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] hold_addr;
    logic              busy;
    logic              done;

`ifdef DMA_ALIGN_EN
    logic parity_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) parity_q <= 1'b0;
        else        parity_q <= ~parity_q;
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (bus.dma_start) state_d = ST_HALT;
            ST_HALT: begin
                // A 6502 write cycle cannot be stalled, so wait for a read.
                if (!bus.cpu_we) begin
`ifdef DMA_ALIGN_EN
                    state_d = parity_q ? ST_READ : ST_ALIGN;
`else
                    state_d = ST_READ;
`endif
                end
            end
            ST_ALIGN: state_d = ST_READ;
            ST_READ:  state_d = ST_WRITE;
            ST_WRITE: state_d = (idx_q == LAST_IDX) ? ST_DONE : ST_READ;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        owner     = OWN_NONE;
        busy      = (state_q != ST_IDLE);
        done      = (state_q == ST_DONE);
        hold_addr = (state_q == ST_DONE) ? dst_q : rd_addr;
        case (state_q)
            ST_IDLE, ST_HALT: owner = OWN_CPU;
            ST_READ:          owner = OWN_DMA_RD;
            ST_WRITE:         owner = OWN_DMA_WR;
            default:          owner = OWN_NONE;
        endcase
    end

    // Page byte and index are concatenated, so the source never carries
    // out of its page.
    assign rd_addr = ADDR_W'({page_q, idx_q});

    always_comb begin
        page_d = page_q;
        dst_d  = dst_q;
        idx_d  = idx_q;
        buf_d  = buf_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.dma_start) begin
                    page_d = bus.dma_page;
                    dst_d  = bus.dma_dst;
                    idx_d  = 8'd0;
                end
            end
            ST_READ:  buf_d = bus.mem_rdata;
            ST_WRITE: idx_d = idx_q + 8'd1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            page_q    <= 8'd0;
            dst_q     <= '0;
            idx_q     <= 8'd0;
            buf_q     <= '0;
            cpu_rdy_q <= 1'b1;
        end else begin
            page_q    <= page_d;
            dst_q     <= dst_d;
            idx_q     <= idx_d;
            buf_q     <= buf_d;
            cpu_rdy_q <= (state_d == ST_IDLE);
        end
    end

    dma_bus_mux #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mux (
        .owner_i     (owner),
        .cpu_addr_i  (bus.cpu_addr),
        .cpu_wdata_i (bus.cpu_wdata),
        .cpu_we_i    (bus.cpu_we),
        .rd_addr_i   (rd_addr),
        .wr_addr_i   (dst_q),
        .hold_addr_i (hold_addr),
        .buf_i       (buf_q),
        .mem_addr_o  (bus.mem_addr),
        .mem_wdata_o (bus.mem_wdata),
        .mem_we_o    (bus.mem_we)
    );

    assign bus.cpu_rdata = bus.mem_rdata;
    assign bus.cpu_rdy   = cpu_rdy_q;
    assign bus.dma_busy  = busy;
    assign bus.dma_done  = done;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Bench for dma_bus_arbiter: a 256-byte and a 4-byte instance, random CPU traffic,
// a cycle-level transfer model and a write scoreboard fed at stimulus time.
module tb_dma_bus_arbiter;
    import dma_arb_pkg::*;

    localparam int NEVER = 32'h3fff_ffff;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   rel = 0;
    int   n_vec = 0;
    int   n_err = 0;

    dma_state_e st0, st1;

    dma_bus_arbiter_if #(.ADDR_W(16), .DATA_W(8)) ifa ();
    dma_bus_arbiter_if #(.ADDR_W(16), .DATA_W(8)) ifb ();

    dma_bus_arbiter #(.ADDR_W(16), .DATA_W(8), .XFER_LEN(256)) dut0 (
        .clk(clk), .reset(rst_n), .bus(ifa), .dbg_state_o(st0));
    dma_bus_arbiter #(.ADDR_W(16), .DATA_W(8), .XFER_LEN(4)) dut1 (
        .clk(clk), .reset(rst_n), .bus(ifb), .dbg_state_o(st1));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory content: page 2 holds i ^ A5, other pages a page-dependent pattern.
    function automatic logic [7:0] mem_byte(logic [15:0] a);
        if (a[15:8] == 8'h02) return a[7:0] ^ 8'hA5;
        return a[7:0] ^ (a[15:8] * 8'd29 + 8'd7);
    endfunction

    assign ifa.mem_rdata = mem_byte(ifa.mem_addr);
    assign ifb.mem_rdata = mem_byte(ifb.mem_addr);

    // Reference model per instance: cycle windows of the transfer.
    int         lo_m[2], he_m[2], fr_m[2], hi_m[2];
    logic [7:0] pg_m[2];
    logic [15:0] dst_m[2];
    logic [23:0] wq0[$];
    logic [23:0] wq1[$];

    task automatic chk(string name, int g, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s inst=%0d cyc=%0d got=%h expected=%h", name, g, cyc, act, exp);
        end
    endtask

    task automatic push_w(int g, logic [15:0] a, logic [7:0] d);
        if (g == 0) wq0.push_back({a, d});
        else        wq1.push_back({a, d});
    endtask

    task automatic set_cpu(int g, logic [15:0] a, logic [7:0] d, logic we);
        if (g == 0) begin ifa.cpu_addr = a; ifa.cpu_wdata = d; ifa.cpu_we = we; end
        else        begin ifb.cpu_addr = a; ifb.cpu_wdata = d; ifb.cpu_we = we; end
    endtask

    task automatic set_dma(int g, logic st, logic [7:0] pg, logic [15:0] ds);
        if (g == 0) begin ifa.dma_start = st; ifa.dma_page = pg; ifa.dma_dst = ds; end
        else        begin ifb.dma_start = st; ifb.dma_page = pg; ifb.dma_dst = ds; end
    endtask

    task automatic drive_defaults();
        for (int g = 0; g < 2; g++) begin
            set_cpu(g, 16'($urandom), 8'($urandom), 1'b0);
            set_dma(g, 1'b0, 8'($urandom), 16'($urandom));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        drive_defaults();
    endtask

    task automatic cpu_wr(int g);
        logic [15:0] a;
        logic [7:0]  d;
        a = 16'($urandom);
        d = 8'($urandom);
        set_cpu(g, a, d, 1'b1);
        push_w(g, a, d);
    endtask

    task automatic xfer(int g, logic [7:0] page, logic [15:0] dst, int h, int gap,
                        bit repulse, bit abort);
        int t, hend, fr, hi, len;
        len = (g == 0) ? 256 : 4;
        for (int i = 0; i < gap; i++) begin
            tick();
            if ($urandom_range(0, 1) == 1) cpu_wr(g);
        end
        tick();
        t = cyc;
        set_dma(g, 1'b1, page, dst);
        if ($urandom_range(0, 1) == 1) cpu_wr(g);
        hend = t + 1 + h;
        fr   = hend + 1;
`ifdef DMA_ALIGN_EN
        if (((fr - rel) & 1) != 0) fr++;
`endif
        hi = fr + 2 * len;
        lo_m[g] = t + 1; he_m[g] = hend; fr_m[g] = fr; hi_m[g] = hi;
        pg_m[g] = page;  dst_m[g] = dst;
        for (int k = 0; k < h; k++) begin
            tick();
            cpu_wr(g);
        end
        tick();
        for (int i = 0; i < len; i++) push_w(g, dst, mem_byte({page, 8'(i)}));
        while (cyc < hi + 1) begin
            tick();
            if (repulse && cyc == t + 6) set_dma(g, 1'b1, page ^ 8'h55, dst ^ 16'h0F0F);
            if (abort && cyc == fr + 128) begin
                rst_n = 1'b0;
                lo_m[g] = NEVER; hi_m[g] = -1; he_m[g] = -1;
                if (g == 0) wq0.delete(); else wq1.delete();
                tick();
                tick();
                rst_n = 1'b1;
                rel = cyc;
                break;
            end
        end
    endtask

    task automatic mon(int g, logic rdy, logic busy, logic done, logic [15:0] addr,
                       logic [7:0] wdata, logic we, logic [7:0] rdata,
                       logic [15:0] caddr, logic cwe);
        logic        busy_e;
        logic [23:0] e;
        if (!rst_n) begin
            chk("rst_rdy", g, 32'(rdy), 32'd1);
            chk("rst_busy", g, 32'(busy), 32'd0);
            chk("rst_done", g, 32'(done), 32'd0);
            chk("rst_addr", g, 32'(addr), 32'(caddr));
        end else begin
            busy_e = (cyc >= lo_m[g]) && (cyc <= hi_m[g]);
            chk("cpu_rdy", g, 32'(rdy), 32'(!busy_e));
            chk("dma_busy", g, 32'(busy), 32'(busy_e));
            chk("dma_done", g, 32'(done), 32'(cyc == hi_m[g]));
            if (!busy_e || cyc <= he_m[g]) begin
                chk("pass_addr", g, 32'(addr), 32'(caddr));
                chk("pass_we", g, 32'(we), 32'(cwe));
            end else if (cyc >= fr_m[g] && cyc < hi_m[g] && ((cyc - fr_m[g]) % 2) == 0) begin
                chk("rd_addr", g, 32'(addr), 32'({pg_m[g], 8'((cyc - fr_m[g]) / 2)}));
                chk("rd_we", g, 32'(we), 32'd0);
            end
        end
        chk("cpu_rdata", g, 32'(rdata), 32'(mem_byte(addr)));
        if (we === 1'b1) begin
            if ((g == 0 && wq0.size() == 0) || (g == 1 && wq1.size() == 0)) begin
                chk("write_unexpected", g, 32'({addr, wdata}), 32'hFFFF_FFFF);
            end else begin
                e = (g == 0) ? wq0.pop_front() : wq1.pop_front();
                chk("write", g, 32'({addr, wdata}), 32'(e));
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0, ifa.cpu_rdy, ifa.dma_busy, ifa.dma_done, ifa.mem_addr, ifa.mem_wdata,
            ifa.mem_we, ifa.cpu_rdata, ifa.cpu_addr, ifa.cpu_we);
        mon(1, ifb.cpu_rdy, ifb.dma_busy, ifb.dma_done, ifb.mem_addr, ifb.mem_wdata,
            ifb.mem_we, ifb.cpu_rdata, ifb.cpu_addr, ifb.cpu_we);
    end

    initial begin
        for (int g = 0; g < 2; g++) begin
            lo_m[g] = NEVER; hi_m[g] = -1; he_m[g] = -1; fr_m[g] = NEVER;
            pg_m[g] = 8'd0;  dst_m[g] = 16'd0;
        end
        rst_n = 1'b0;
        drive_defaults();
        for (int i = 0; i < 3; i++) begin
            tick();
            set_cpu(0, 16'h1234, 8'h00, 1'b0);
            set_cpu(1, 16'h1234, 8'h00, 1'b0);
        end
        tick();
        rst_n = 1'b1;
        rel = cyc;

        xfer(0, 8'h02, 16'h2004, 0, 2, 1'b0, 1'b0);
        xfer(0, 8'($urandom), 16'($urandom), 3, 1, 1'b0, 1'b0);
        xfer(0, 8'($urandom), 16'($urandom), 0, 3, 1'b1, 1'b0);
        xfer(1, 8'hFF, 16'($urandom), 0, 1, 1'b0, 1'b0);
        xfer(1, 8'hFF, 16'($urandom), 1, 2, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++)
            xfer(1, 8'($urandom), 16'($urandom), $urandom_range(0, 3),
                 $urandom_range(1, 3), 1'b0, 1'b0);
        xfer(0, 8'($urandom), 16'($urandom), $urandom_range(0, 2), 1, 1'b0, 1'b1);
        xfer(1, 8'($urandom), 16'($urandom), 0, 1, 1'b0, 1'b0);

        for (int i = 0; i < 4; i++) tick();
        chk("wq0_drained", 0, 32'(wq0.size()), 32'd0);
        chk("wq1_drained", 1, 32'(wq1.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dma_bus_arbiter.md
# dma_bus_arbiter

Shares the 6502 core's single memory bus between the CPU and a page-copy DMA engine (OAM-style sprite DMA). On `dma_start` it halts the CPU via RDY at a read cycle, then alternates read/write cycles to copy `XFER_LEN` bytes from page `dma_page` to one fixed destination register. It then returns the bus to the CPU. It sits between the Controller/datapath address-data bus and system memory.

## Interface
- `ADDR_W`, 16, address width
- `DATA_W`, 8, data width
- `XFER_LEN`, 256, bytes per transfer; power of 2, 2..256
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-low (0 = reset)
- `cpu_addr`  in  ADDR_W  CPU bus address
- `cpu_wdata`  in  DATA_W  CPU write data
- `cpu_we`  in  1  CPU write strobe (1 = write cycle)
- `cpu_rdata`  out  DATA_W  read data to CPU; always equals `mem_rdata`
- `cpu_rdy`  out  1  RDY to CPU; 0 = CPU stalled
- `dma_start`  in  1  single-cycle start request
- `dma_page`  in  8  source page (high address byte), latched at start
- `dma_dst`  in  ADDR_W  destination address, latched at start
- `dma_busy`  out  1  transfer in progress
- `dma_done`  out  1  one-cycle completion pulse
- `mem_addr`  out  ADDR_W  memory address
- `mem_wdata`  out  DATA_W  memory write data
- `mem_we`  out  1  memory write enable
- `mem_rdata`  in  DATA_W  memory read data, combinational, valid in the same cycle

## Operation
- States: IDLE, HALT, ALIGN (only with the macro), READ, WRITE, DONE.
- Bus mux: in IDLE and HALT, `mem_*` = `cpu_*`. In READ, address = {page, idx}, `mem_we` = 0. In WRITE, address = dst, `mem_we` = 1, `mem_wdata` = byte buffer. In ALIGN and DONE, `mem_we` = 0 and the address holds its last DMA value.
- IDLE: `cpu_rdy` = 1. `dma_start` = 1 latches page and dst, clears idx → HALT.
- HALT: `cpu_rdy` = 0, `dma_busy` = 1.
  - `cpu_we` = 1: the CPU write completes (6502 RDY cannot stall writes); stay in HALT.
  - `cpu_we` = 0: → READ (or → ALIGN, see Configuration).
- READ: buffer ← `mem_rdata` at the cycle end → WRITE.
- WRITE: idx ← idx + 1.
  - If idx was `XFER_LEN`-1 → DONE.
  - Otherwise → READ.
- DONE: `dma_done` = 1, `cpu_rdy` = 0 → IDLE.
- `dma_start` outside IDLE is ignored; no queuing.
- idx is 8 bits and wraps within the page. The source address never carries into the high byte.

## Timing
- Reset values: state IDLE, `cpu_rdy` = 1, `dma_busy` = 0, `dma_done` = 0, idx = 0, buffer = 0, parity = 0. `mem_*` mirror `cpu_*`.
- `dma_start` high in cycle T gives HALT in T+1.
- If the CPU reads in T+1, the first READ is in T+2. The last WRITE is in T+1+2·`XFER_LEN`, DONE follows it, and IDLE (`cpu_rdy` = 1) follows DONE.
- Each extra consecutive CPU write cycle in HALT adds one cycle.
- `dma_busy` is high from HALT through DONE inclusive.
- `cpu_rdy` is a registered function of state only; there is no combinational path from `dma_start` to it.
- Reset asserted mid-transfer: immediate return to IDLE, `cpu_rdy` = 1. The partial copy is abandoned and `dma_done` does not pulse.

## Configuration
- `DMA_ALIGN_EN` defined: adds a free-running parity flop that toggles every cycle, reset value 0.
  - READ cycles must fall on parity 0.
  - Leaving HALT: if parity = 1 → READ; if parity = 0 → ALIGN (one dead cycle, `cpu_rdy` = 0) → READ.
  - Transfer length is therefore 1 + 2·`XFER_LEN` or 2 + 2·`XFER_LEN` cycles plus halt.
- `DMA_ALIGN_EN` undefined: no ALIGN state and no parity flop; HALT → READ directly.

## Structure
- Package `dma_arb_pkg` holds:
  - the state enum typedef (3 bits);
  - the `DMA_XFER_LEN_DEFAULT` constant;
  - the owner-select typedef (CPU/DMA_RD/DMA_WR/NONE).
- One natural sub-module: `dma_bus_mux`, the combinational selection of `mem_addr`, `mem_wdata` and `mem_we` from owner select.
- The FSM, idx counter, buffer and parity stay in the top module.

## Test plan
- Reset held low with `cpu_addr`=16'h1234 → `cpu_rdy`=1, `dma_busy`=0, `mem_addr`=16'h1234. Mid-transfer reset at idx=16'h40 → IDLE next cycle, no `dma_done`.
- `dma_page`=8'h02, `dma_dst`=16'h2004, CPU reading, memory page 2 = i ^ 8'hA5 → 256 writes to 16'h2004 with data i ^ 8'hA5 in order. `dma_done` pulses exactly at cycle T+514 (macro undefined).
- CPU asserts `cpu_we`=1 for 3 cycles after start → stays in HALT 3 extra cycles, `mem_we` follows the CPU, the first READ is delayed by 3.
- `dma_start` re-pulsed while `dma_busy`=1 → ignored; the transfer count stays 256 and page/dst are unchanged.
- `XFER_LEN`=4, page 8'hFF → reads 16'hFF00..16'hFF03 only, no carry past 16'hFFFF, DONE after 8 DMA cycles.
- `DMA_ALIGN_EN` defined: start with HALT on parity 0 → one ALIGN cycle, READ on parity 0. Start on parity 1 → no ALIGN; every READ has parity 0.
